// File: rtl/ord_dispatch_pkg.sv
// Shared parameters and width helpers for the ordered-request dispatcher.
package ord_dispatch_pkg;

    localparam int unsigned ORD_DEPTH_DEF = 4;
    localparam int unsigned MAX_OUTS_DEF  = 4;
    localparam int unsigned ADDR_W_DEF    = 32;
    localparam int unsigned LEN_W_DEF     = 16;

    // Width of an ID; a single-ID configuration still needs one bit.
    function automatic int unsigned id_w_of(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Width that holds the total outstanding count across every ID.
    function automatic int unsigned outs_cnt_w(input int unsigned depth,
                                               input int unsigned max_outs);
        return $clog2(depth * max_outs + 1);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin search for the first eligible ID at or after the pointer.
module rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_any
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant  = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!found && eligible[ID_W'(idx)]) begin
                found               = 1'b1;
                grant[ID_W'(idx)]   = 1'b1;
                gnt_id              = ID_W'(idx);
            end
        end
    end

    assign gnt_any = |eligible;

endmodule

// File: rtl/ord_dispatcher.sv
// Issues upstream requests to a downstream port with round-robin IDs, mirrors
// each issue onto a reorder-buffer order port, and tracks per-ID credits.
module ord_dispatcher
    import ord_dispatch_pkg::*;
#(
    parameter int unsigned ORD_DEPTH = ORD_DEPTH_DEF,
    parameter int unsigned ID_W      = id_w_of(ORD_DEPTH),
    parameter int unsigned MAX_OUTS  = MAX_OUTS_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [ADDR_W-1:0]                           in_addr,
    input  logic [LEN_W-1:0]                            in_len,
    input  logic                                        in_vld,
    output logic                                        in_rdy,
    output logic [ID_W-1:0]                             m_id,
    output logic [ADDR_W-1:0]                           m_addr,
    output logic [LEN_W-1:0]                            m_len,
    output logic                                        m_vld,
    input  logic                                        m_rdy,
    output logic [ID_W-1:0]                             ord_id,
    output logic [LEN_W-1:0]                            ord_len,
    output logic                                        ord_vld,
    input  logic                                        ord_rdy,
    input  logic [ID_W-1:0]                             cpl_id,
    input  logic                                        cpl_vld,
    output logic [outs_cnt_w(ORD_DEPTH, MAX_OUTS)-1:0]  outs_cnt,
    output logic                                        cpl_err
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUTS + 1);
    localparam int unsigned OUTS_W = outs_cnt_w(ORD_DEPTH, MAX_OUTS);

    logic [CNT_W-1:0]     cnt_q [ORD_DEPTH];
    logic [CNT_W-1:0]     cnt_d [ORD_DEPTH];
    logic [ID_W-1:0]      ptr_q, ptr_d;
    logic                 m_vld_q, m_vld_d;
    logic [ID_W-1:0]      m_id_q, m_id_d;
    logic [ADDR_W-1:0]    m_addr_q, m_addr_d;
    logic [LEN_W-1:0]     m_len_q, m_len_d;
    logic                 ord_vld_q, ord_vld_d;
    logic [ID_W-1:0]      ord_id_q, ord_id_d;
    logic [LEN_W-1:0]     ord_len_q, ord_len_d;
    logic [OUTS_W-1:0]    outs_cnt_q, outs_cnt_d;
    logic                 cpl_err_q, cpl_err_d;

    logic [ORD_DEPTH-1:0] eligible;
    logic [ORD_DEPTH-1:0] grant;
    logic [ID_W-1:0]      gnt_id;
    logic                 gnt_any;
    logic                 issue;
    logic                 cpl_in_range;
    logic                 cpl_ok;

    // An ID is eligible only on its registered count, so a same-cycle
    // completion cannot open a slot until the following cycle.
    always_comb begin
        for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
            eligible[i] = (32'(cnt_q[i]) < MAX_OUTS);
        end
    end

    rr_picker #(
        .N    (ORD_DEPTH),
        .ID_W (ID_W)
    ) u_rr_picker (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (grant),
        .gnt_id   (gnt_id),
        .gnt_any  (gnt_any)
    );

    assign in_rdy       = gnt_any && (!m_vld_q || m_rdy) && (!ord_vld_q || ord_rdy);
    assign issue        = in_vld && in_rdy;
    assign cpl_in_range = (32'(cpl_id) < ORD_DEPTH);
    assign cpl_ok       = cpl_vld && cpl_in_range && (cnt_q[cpl_id] != '0);

    // Credit update, output register loading and the running total.
    always_comb begin
        ptr_d      = ptr_q;
        m_vld_d    = m_vld_q;
        m_id_d     = m_id_q;
        m_addr_d   = m_addr_q;
        m_len_d    = m_len_q;
        ord_vld_d  = ord_vld_q;
        ord_id_d   = ord_id_q;
        ord_len_d  = ord_len_q;
        outs_cnt_d = '0;
        cpl_err_d  = cpl_err_q || (cpl_vld && !cpl_ok);

        for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if ((issue && grant[i]) && !(cpl_ok && (32'(cpl_id) == i))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (!(issue && grant[i]) && (cpl_ok && (32'(cpl_id) == i))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            outs_cnt_d = outs_cnt_d + OUTS_W'(cnt_d[i]);
        end

        if (issue) begin
            ptr_d     = (32'(gnt_id) == ORD_DEPTH - 1) ? '0 : gnt_id + ID_W'(1);
            m_vld_d   = 1'b1;
            m_id_d    = gnt_id;
            m_addr_d  = in_addr;
            m_len_d   = in_len;
            ord_vld_d = 1'b1;
            ord_id_d  = gnt_id;
            ord_len_d = in_len;
        end else begin
            if (m_rdy) begin
                m_vld_d = 1'b0;
            end
            if (ord_rdy) begin
                ord_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
            ptr_q      <= '0;
            m_vld_q    <= 1'b0;
            m_id_q     <= '0;
            m_addr_q   <= '0;
            m_len_q    <= '0;
            ord_vld_q  <= 1'b0;
            ord_id_q   <= '0;
            ord_len_q  <= '0;
            outs_cnt_q <= '0;
            cpl_err_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < ORD_DEPTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ptr_q      <= ptr_d;
            m_vld_q    <= m_vld_d;
            m_id_q     <= m_id_d;
            m_addr_q   <= m_addr_d;
            m_len_q    <= m_len_d;
            ord_vld_q  <= ord_vld_d;
            ord_id_q   <= ord_id_d;
            ord_len_q  <= ord_len_d;
            outs_cnt_q <= outs_cnt_d;
            cpl_err_q  <= cpl_err_d;
        end
    end

    assign m_vld    = m_vld_q;
    assign m_id     = m_id_q;
    assign m_addr   = m_addr_q;
    assign m_len    = m_len_q;
    assign ord_vld  = ord_vld_q;
    assign ord_id   = ord_id_q;
    assign ord_len  = ord_len_q;
    assign outs_cnt = outs_cnt_q;
    assign cpl_err  = cpl_err_q;

endmodule
